// File: rtl/equiv_compare_arbiter.sv
// Round-robin shared logical-equivalence compare unit: grants one requester at a
// time, registers its operand pair and returns a tagged one-cycle response.
module equiv_compare_arbiter #(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [R-1:0]         req,
  input  logic [R*N-1:0]       d1,
  input  logic [R*N-1:0]       d2,
  output logic [R-1:0]         gnt,
  output logic                 rsp_valid,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic                 rsp_equivalent
);

  localparam int IW = $clog2(R);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr_next;
  logic [IW:0]   cand;
  logic          found;
  logic [N-1:0]  op1;
  logic [N-1:0]  op2;
  logic          eq_r;

  // Search upward from ptr with wrap; one extra bit keeps ptr+k from overflowing.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < R; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(R)) begin
        cand = cand - (IW+1)'(R);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  assign ptr_next = (winner == IW'(R-1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state          <= IDLE;
      gnt            <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_equivalent <= 1'b0;
      op1            <= '0;
      op2            <= '0;
      eq_r           <= 1'b0;
      ptr            <= '0;
      owner          <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= R'(1) << winner;
            op1   <= d1[winner*N +: N];
            op2   <= d2[winner*N +: N];
            owner <= winner;
            ptr   <= ptr_next;
            state <= CMP;
          end
        end
        CMP: begin
          eq_r  <= (|op1) ~^ (|op2);
          state <= RESP;
        end
        RESP: begin
          rsp_valid      <= 1'b1;
          rsp_id         <= owner;
          rsp_equivalent <= eq_r;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_compare_arbiter.sv
// Scoreboard bench for equiv_compare_arbiter: a round-robin reference model
// predicts each grant and response; a negedge monitor pops and compares them.
module tb_equiv_compare_arbiter;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int IW = $clog2(R);

  typedef struct {
    int id;
    bit eq;
  } rsp_t;

  logic            clk;
  logic            rstN;
  logic [R-1:0]    req;
  logic [R*N-1:0]  d1;
  logic [R*N-1:0]  d2;
  logic [R-1:0]    gnt;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic            rsp_equivalent;

  logic [N-1:0]    opA [R];
  logic [N-1:0]    opB [R];

  int   expGnt [$];
  rsp_t expRsp [$];
  int   gntCyc [$];

  int   nCompared;
  int   nMismatched;
  int   cyc;
  int   mPtr;
  int   lastWinner;
  int   holdId;
  bit   holdEq;
  logic [R-1:0] nr;

  equiv_compare_arbiter #(.N(N), .R(R)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .req            (req),
    .d1             (d1),
    .d2             (d2),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_equivalent (rsp_equivalent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    d1 = '0;
    d2 = '0;
    for (int i = 0; i < R; i++) begin
      d1[i*N +: N] = opA[i];
      d2[i*N +: N] = opB[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Logical equivalence of the two "is non-zero" flags.
  function automatic bit refEquiv(input logic [N-1:0] a, input logic [N-1:0] b);
    bit x;
    bit y;
    x = (a != 0);
    y = (b != 0);
    return (!x || y) && (!y || x);
  endfunction

  task automatic randOps(input int i);
    opA[i] = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
    opB[i] = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
  endtask

  task automatic waitGrant(input int delay);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (gnt != 0) seen = 1'b1;
    end
    checkOutput("grant_seen", 32'(seen), 32'd1);
    checkOutput("grant_delay", n, delay);
  endtask

  // Present a request vector, predict the winner from the rotating priority
  // and queue the expected grant and response, then wait for the grant.
  task automatic applyStimulus(input logic [R-1:0] newReq, input int delay);
    int   w;
    int   c;
    rsp_t e;
    req = newReq;
    w = -1;
    for (int k = 0; k < R; k++) begin
      c = (mPtr + k) % R;
      if (w < 0 && ((newReq >> c) & 1) != 0) w = c;
    end
    if (w >= 0) begin
      expGnt.push_back(w);
      e.id = w;
      e.eq = refEquiv(opA[w], opB[w]);
      expRsp.push_back(e);
      mPtr       = (w + 1) % R;
      lastWinner = w;
      waitGrant(delay);
    end
  endtask

  always @(negedge clk) begin
    int   w;
    rsp_t e;
    if (!rstN) begin
      holdId = 0;
      holdEq = 1'b0;
    end else begin
      checkOutput("gnt_onehot", 32'(((gnt & (gnt - 1'b1)) == 0)), 32'd1);
      if (gnt != 0) begin
        if (expGnt.size() == 0) begin
          checkOutput("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          w = expGnt.pop_front();
          checkOutput("gnt_vector", 32'(gnt), 32'(1) << w);
          gntCyc.push_back(cyc);
        end
      end
      if (rsp_valid) begin
        if (expRsp.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = expRsp.pop_front();
          checkOutput("rsp_id", 32'(rsp_id), e.id);
          checkOutput("rsp_equivalent", 32'(rsp_equivalent), 32'(e.eq));
          if (gntCyc.size() == 0) checkOutput("rsp_grant_pending", 32'(gntCyc.size()), 32'd1);
          else checkOutput("rsp_latency", cyc - gntCyc.pop_front(), 32'd2);
          holdId = e.id;
          holdEq = e.eq;
        end
      end else begin
        checkOutput("rsp_id_hold", 32'(rsp_id), holdId);
        checkOutput("rsp_eq_hold", 32'(rsp_equivalent), 32'(holdEq));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    mPtr        = 0;
    lastWinner  = 0;
    rstN        = 1'b0;
    req         = '0;
    for (int i = 0; i < R; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    // Reset for two cycles, then an idle stretch with no requests.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rstN = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      checkOutput("idle_gnt", 32'(gnt), 32'd0);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("idle_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("idle_rsp_eq", 32'(rsp_equivalent), 32'd0);
    end

    // Single requester 1, both operands non-zero.
    opA[1] = 8'h01;
    opB[1] = 8'h05;
    applyStimulus(4'b0010, 1);
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single requester 0, one zero operand.
    opA[0] = 8'h00;
    opB[0] = 8'h05;
    applyStimulus(4'b0001, 1);
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // All requesters held continuously: strict rotation, one grant per 3 cycles.
    for (int i = 0; i < R; i++) randOps(i);
    applyStimulus(4'b1111, 1);
    for (int j = 0; j < 4; j++) begin
      randOps(lastWinner);
      applyStimulus(4'b1111, 3);
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // Requester 2 arrives while requester 3 is in its response phase.
    randOps(3);
    applyStimulus(4'b1000, 1);
    req = '0;
    @(posedge clk);
    #1;
    randOps(2);
    applyStimulus(4'b0100, 2);

    // Randomized contention: granted requesters drop or re-arm, others join.
    for (int it = 0; it < 150; it++) begin
      nr = req;
      nr = nr & ~(R'(1) << lastWinner);
      if ($urandom_range(0, 1) == 1) begin
        nr = nr | (R'(1) << lastWinner);
        randOps(lastWinner);
      end
      for (int i = 0; i < R; i++) begin
        if (((nr >> i) & 1) == 0 && i != lastWinner && $urandom_range(0, 2) == 0) begin
          nr = nr | (R'(1) << i);
          randOps(i);
        end
      end
      if (nr == 0) begin
        req = '0;
        repeat (2 + $urandom_range(0, 3)) @(posedge clk);
        #1;
        nr = R'($urandom_range(1, (1 << R) - 1));
        for (int i = 0; i < R; i++) if (((nr >> i) & 1) != 0) randOps(i);
        applyStimulus(nr, 1);
      end else begin
        applyStimulus(nr, 3);
      end
    end

    // Reset pulsed during the compare phase aborts the transaction.
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    randOps(1);
    applyStimulus(4'b0010, 1);
    #1;
    rstN = 1'b0;
    req  = '0;
    #1;
    checkOutput("abort_gnt", 32'(gnt), 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("abort_rsp_eq", 32'(rsp_equivalent), 32'd0);
    expGnt.delete();
    expRsp.delete();
    gntCyc.delete();
    mPtr = 0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    randOps(1);
    randOps(2);
    applyStimulus(4'b0110, 1);
    req = '0;
    repeat (4) @(posedge clk);
    #1;

    checkOutput("drain_grants", expGnt.size(), 32'd0);
    checkOutput("drain_responses", expRsp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
